// File: rtl/serial_addsub_n_if.sv
// Request/result bundle for serial_addsub_n.
// The sub signal exists only when SERIAL_ADDSUB_SUB_EN is defined.
interface serial_addsub_n_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDSUB_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
`ifdef SERIAL_ADDSUB_SUB_EN
    output sub,
`endif
    output start, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef SERIAL_ADDSUB_SUB_EN
    input  sub,
`endif
    input  start, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one full-adder slice.
// Subtract support (sub input) is built only when SERIAL_ADDSUB_SUB_EN is defined.
module serial_addsub_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               clk,
  input logic               reset,
  serial_addsub_n_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-2:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               bit_s;
  logic               cnew_s;
  logic               last_s;
  logic [WIDTH-1:0]   acc_sh_s;

  // Full-adder slice on the current LSBs and the registered carry
  assign bit_s    = a_q[0] ^ b_q[0] ^ carry_q;
  assign cnew_s   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign last_s   = (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_sh_s = {bit_s, acc_q};

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
`ifdef SERIAL_ADDSUB_SUB_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
`else
          b_d     = bus.b;
          carry_d = 1'b0;
`endif
          cnt_d   = {CNT_W{1'b0}};
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        carry_d = cnew_s;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_sh_s[WIDTH-1:1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_s) begin
          // carry_q here is the carry into the MSB slice
          sum_d   = acc_sh_s;
          cout_d  = cnew_s;
          ovf_d   = carry_q ^ cnew_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(WIDTH-1){1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule
